// File: rtl/qam_reg_bank_pkg.sv
// Shared definitions for the QAM register bank: address map, CTRL bit positions,
// FSM state encoding and the buffered command format.
package qam_reg_bank_pkg;

   localparam int FIFO_DEPTH_DEF = 4;
   localparam int SCRATCH_N_DEF  = 16;
   localparam int ADDR_W         = 10;
   localparam int DATA_W         = 8;

   localparam logic [ADDR_W-1:0] ADDR_CTRL   = 10'h200;
   localparam logic [ADDR_W-1:0] ADDR_STATUS = 10'h201;

   localparam int CTRL_MOD_EN  = 0;
   localparam int CTRL_MAPPING = 1;
   localparam int CTRL_ERR_CLR = 7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DEC  = 2'd1,
      ST_RD   = 2'd2,
      ST_WR   = 2'd3
   } state_t;

   typedef struct packed {
      logic              rw;
      logic [ADDR_W-1:0] addr;
   } cmd_t;

endpackage

// File: rtl/qam_sync_fifo.sv
// Show-ahead synchronous FIFO with registered occupancy count.
// Illegal push (full) or pop (empty) is ignored; a simultaneous push+pop applies each legal half.
module qam_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // Storage is cleared on reset so the show-ahead output reads zero after reset.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/qam_reg_bank.sv
// Register bank behind the SPI slave: executes buffered {rw,addr} commands one at a time
// against scratch bytes, CTRL and STATUS; stalls in RD on full read FIFO, in WR on missing data.
module qam_reg_bank
   import qam_reg_bank_pkg::*;
#(
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int SCRATCH_N  = SCRATCH_N_DEF
) (
   input  logic              CLK,
   input  logic              rst,
   input  logic              cmd_push,
   input  logic              cmd_rw,
   input  logic [ADDR_W-1:0] cmd_addr,
   output logic              cmd_full,
   input  logic              wdata_push,
   input  logic [DATA_W-1:0] wdata_in,
   output logic              wdata_full,
   input  logic              rdata_pop,
   output logic [DATA_W-1:0] rdata_out,
   output logic              rdata_empty,
   output logic              rdata_ready,
   output logic              mod_enable,
   output logic              mapping,
   output logic              err_sticky
);

   localparam int SW = (SCRATCH_N > 1) ? $clog2(SCRATCH_N) : 1;

   state_t            state;
   state_t            state_nxt;
   cmd_t              cmd_din;
   cmd_t              cmd_dout;
   cmd_t              cmd_q;
   logic              cmd_empty;
   logic              cmd_pop;
   logic [DATA_W-1:0] wd_dout;
   logic              wd_empty;
   logic              wd_pop;
   logic [DATA_W-1:0] rd_din;
   logic              rd_full;
   logic              rd_push;
   logic              wr_commit;
   logic [DATA_W-1:0] scratch [SCRATCH_N];
   logic [1:0]        ctrl;
   logic              hit_scr;
   logic              hit_ctrl;
   logic              hit_status;
   logic [SW-1:0]     scr_idx;
   logic              rd_bad;
   logic              wr_bad;

   assign cmd_din = '{rw: cmd_rw, addr: cmd_addr};

   qam_sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
      .CLK(CLK), .rst(rst),
      .push(cmd_push), .din(cmd_din), .pop(cmd_pop),
      .dout(cmd_dout), .full(cmd_full), .empty(cmd_empty)
   );

   qam_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_wdata_fifo (
      .CLK(CLK), .rst(rst),
      .push(wdata_push), .din(wdata_in), .pop(wd_pop),
      .dout(wd_dout), .full(wdata_full), .empty(wd_empty)
   );

   qam_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rdata_fifo (
      .CLK(CLK), .rst(rst),
      .push(rd_push), .din(rd_din), .pop(rdata_pop),
      .dout(rdata_out), .full(rd_full), .empty(rdata_empty)
   );

   assign rdata_ready = ~rdata_empty & (state != ST_RD);

   assign hit_scr    = (cmd_q.addr < ADDR_W'(SCRATCH_N));
   assign hit_ctrl   = (cmd_q.addr == ADDR_CTRL);
   assign hit_status = (cmd_q.addr == ADDR_STATUS);
   assign scr_idx    = cmd_q.addr[SW-1:0];
   assign wr_bad     = ~hit_scr & ~hit_ctrl;

   always_comb begin
      rd_din = '0;
      rd_bad = 1'b0;
      if (hit_scr)
         rd_din = scratch[scr_idx];
      else if (hit_ctrl)
         rd_din = {6'b0, ctrl};
      else if (hit_status)
         rd_din = {4'b0, err_sticky, cmd_full, wdata_full, rdata_empty};
      else
         rd_bad = 1'b1;
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmd_pop   = 1'b0;
      wd_pop    = 1'b0;
      rd_push   = 1'b0;
      wr_commit = 1'b0;
      case (state)
         ST_IDLE: if (!cmd_empty) begin
            cmd_pop   = 1'b1;
            state_nxt = ST_DEC;
         end
         ST_DEC: state_nxt = cmd_q.rw ? ST_WR : ST_RD;
         ST_RD: if (!rd_full) begin
            rd_push   = 1'b1;
            state_nxt = ST_IDLE;
         end
         ST_WR: if (!wd_empty) begin
            wd_pop    = 1'b1;
            wr_commit = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst)          cmd_q <= '0;
      else if (cmd_pop) cmd_q <= cmd_dout;
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SCRATCH_N; i++) scratch[i] <= '0;
      end else if (wr_commit && hit_scr) begin
         scratch[scr_idx] <= wd_dout;
      end
   end

   // Modulator outputs are re-registered from CTRL, so they follow a commit by one cycle.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         ctrl       <= '0;
         err_sticky <= 1'b0;
         mod_enable <= 1'b0;
         mapping    <= 1'b0;
      end else begin
         if (wr_commit && hit_ctrl) begin
            ctrl <= wd_dout[1:0];
            if (wd_dout[CTRL_ERR_CLR]) err_sticky <= 1'b0;
         end
         if ((wr_commit && wr_bad) || (rd_push && rd_bad)) err_sticky <= 1'b1;
         mod_enable <= ctrl[CTRL_MOD_EN];
         mapping    <= ctrl[CTRL_MAPPING];
      end
   end

endmodule

// File: tb/tb_qam_reg_bank.sv
// Scoreboard bench for qam_reg_bank: reference model predicts read data at issue time,
// an independent monitor pops the read FIFO and compares.
module tb_qam_reg_bank;

   localparam int BIG = 1000000;

   logic       CLK = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_push = 1'b0;
   logic       cmd_rw = 1'b0;
   logic [9:0] cmd_addr = '0;
   logic       cmd_full;
   logic       wdata_push = 1'b0;
   logic [7:0] wdata_in = '0;
   logic       wdata_full;
   logic       rdata_pop = 1'b0;
   logic [7:0] rdata_out;
   logic       rdata_empty;
   logic       rdata_ready;
   logic       mod_enable;
   logic       mapping;
   logic       err_sticky;

   qam_reg_bank dut (
      .CLK(CLK), .rst(rst),
      .cmd_push(cmd_push), .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_full(cmd_full),
      .wdata_push(wdata_push), .wdata_in(wdata_in), .wdata_full(wdata_full),
      .rdata_pop(rdata_pop), .rdata_out(rdata_out), .rdata_empty(rdata_empty),
      .rdata_ready(rdata_ready), .mod_enable(mod_enable), .mapping(mapping),
      .err_sticky(err_sticky)
   );

   always #5 CLK = ~CLK;

   int          errors = 0;
   int          checks = 0;
   logic [15:0] sb_q[$];
   int          pop_budget = 0;
   bit          rand_pop = 1'b0;

   logic [7:0]  m_scr [16];
   logic [1:0]  m_ctrl;
   logic        m_err;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_scr[i] = 8'h00;
      m_ctrl = 2'b00;
      m_err  = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic push_cmd(input logic rw, input logic [9:0] a);
      int t = 0;
      while (cmd_full && t < 300) begin @(posedge CLK); #1; t++; end
      if (t >= 300) timeout("cmd_full_wait");
      cmd_rw = rw; cmd_addr = a; cmd_push = 1'b1;
      @(posedge CLK); #1;
      cmd_push = 1'b0;
   endtask

   task automatic push_wdata(input logic [7:0] d);
      int t = 0;
      while (wdata_full && t < 300) begin @(posedge CLK); #1; t++; end
      if (t >= 300) timeout("wdata_full_wait");
      wdata_in = d; wdata_push = 1'b1;
      @(posedge CLK); #1;
      wdata_push = 1'b0;
   endtask

   task automatic do_read(input logic [9:0] a);
      logic [7:0] e, m;
      e = 8'h00; m = 8'hFF;
      if (a < 10'd16)        e = m_scr[a[3:0]];
      else if (a == 10'h200) e = {6'b0, m_ctrl};
      else if (a == 10'h201) begin e = {4'b0, m_err, 3'b0}; m = 8'hF8; end
      else                   m_err = 1'b1;
      sb_q.push_back({m, e});
      push_cmd(1'b0, a);
   endtask

   task automatic model_write(input logic [9:0] a, input logic [7:0] d);
      if (a < 10'd16) m_scr[a[3:0]] = d;
      else if (a == 10'h200) begin
         m_ctrl = d[1:0];
         if (d[7]) m_err = 1'b0;
      end else m_err = 1'b1;
   endtask

   task automatic do_write(input logic [9:0] a, input logic [7:0] d);
      model_write(a, d);
      push_wdata(d);
      push_cmd(1'b1, a);
   endtask

   task automatic drain();
      int t = 0;
      pop_budget = BIG;
      while (sb_q.size() != 0 && t < 3000) begin @(posedge CLK); #1; t++; end
      if (t >= 3000) timeout("drain");
      wait_cycles(10);
   endtask

   // Monitor: pops the read FIFO when allowed and checks each byte against the scoreboard.
   initial begin
      logic [15:0] e;
      forever begin
         @(negedge CLK);
         rdata_pop = 1'b0;
         if (!rst && !rdata_empty && pop_budget > 0 &&
             (!rand_pop || $urandom_range(2) != 0)) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rdata: got 0x%02h with nothing expected at %0t", rdata_out, $time);
            end else begin
               e = sb_q.pop_front();
               chk("rdata", int'(rdata_out & e[15:8]), int'(e[7:0]));
            end
            rdata_pop = 1'b1;
            pop_budget--;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] a;
      logic [7:0] d;
      int k;
      model_reset();
      rst = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_cmd_full", cmd_full, 0);
      chk("rst_wdata_full", wdata_full, 0);
      chk("rst_rdata_empty", rdata_empty, 1);
      chk("rst_rdata_ready", rdata_ready, 0);
      chk("rst_rdata_out", rdata_out, 0);
      chk("rst_mod_enable", mod_enable, 0);
      chk("rst_mapping", mapping, 0);
      chk("rst_err", err_sticky, 0);
      @(posedge CLK); #1;
      rst = 1'b0;
      wait_cycles(2);

      // CTRL write latency to modulator outputs, then read-back
      pop_budget = 0;
      model_write(10'h200, 8'h03);
      push_wdata(8'h03);
      push_cmd(1'b1, 10'h200);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("ctrl_mod_en_early", mod_enable, 0);
      @(posedge CLK);
      @(negedge CLK);
      chk("ctrl_mod_en", mod_enable, 1);
      chk("ctrl_mapping", mapping, 1);
      @(posedge CLK); #1;
      do_read(10'h200);
      drain();

      // scratch write/read with read latency
      pop_budget = 0;
      do_write(10'h007, 8'hA5);
      wait_cycles(6);
      do_read(10'h007);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rd_lat_empty_n3", rdata_empty, 1);
      @(posedge CLK);
      @(negedge CLK);
      chk("rd_lat_empty_n4", rdata_empty, 0);
      @(posedge CLK); #1;
      drain();

      // backpressure: read FIFO full, FSM stalls in RD, command FIFO fills
      pop_budget = 0;
      for (int i = 0; i < 9; i++) do_read(10'h007);
      wait_cycles(20);
      chk("bp_cmd_full", cmd_full, 1);
      chk("bp_rdata_ready", rdata_ready, 0);
      chk("bp_rdata_empty", rdata_empty, 0);
      cmd_rw = 1'b0; cmd_addr = 10'h007; cmd_push = 1'b1;
      @(posedge CLK); #1;
      cmd_push = 1'b0;
      wait_cycles(5);
      chk("bp_cmd_full_hold", cmd_full, 1);
      pop_budget = 1;
      wait_cycles(10);
      chk("bp_one_pop_cmd_full", cmd_full, 0);
      chk("bp_one_pop_refill", rdata_ready, 0);
      drain();
      chk("bp_no_extra", rdata_empty, 1);

      // reset during an RD stall
      pop_budget = 0;
      for (int i = 0; i < 5; i++) push_cmd(1'b0, 10'h007);
      push_wdata(8'h77);
      wait_cycles(15);
      chk("stall_before_rst", rdata_ready, 0);
      rst = 1'b1;
      @(negedge CLK);
      chk("mid_rst_cmd_full", cmd_full, 0);
      chk("mid_rst_wdata_full", wdata_full, 0);
      chk("mid_rst_rdata_empty", rdata_empty, 1);
      chk("mid_rst_mod_enable", mod_enable, 0);
      chk("mid_rst_mapping", mapping, 0);
      @(posedge CLK); #1;
      rst = 1'b0;
      model_reset();
      wait_cycles(3);
      do_read(10'h007);
      drain();

      // write command whose data arrives late
      pop_budget = BIG;
      model_write(10'h003, 8'h5C);
      push_cmd(1'b1, 10'h003);
      do_read(10'h003);
      wait_cycles(10);
      chk("late_wd_rdata_empty", rdata_empty, 1);
      chk("late_wd_mod_enable", mod_enable, 0);
      push_wdata(8'h5C);
      drain();

      // error flag: unmapped read, STATUS, write-1-to-clear keeps CTRL bits
      do_write(10'h200, 8'h02);
      do_read(10'h3FF);
      drain();
      chk("err_set", err_sticky, 1);
      do_read(10'h201);
      drain();
      do_write(10'h200, {6'b100000, m_ctrl});
      wait_cycles(8);
      chk("err_clr", err_sticky, 0);
      chk("err_clr_mapping", mapping, 1);
      chk("err_clr_mod_en", mod_enable, 0);

      // randomized traffic with random read-side backpressure
      rand_pop = 1'b1;
      pop_budget = BIG;
      for (int n = 0; n < 300; n++) begin
         k = $urandom_range(7);
         d = 8'($urandom);
         case (k)
            0, 1: do_write(10'($urandom_range(15)), d);
            2, 3: do_read(10'($urandom_range(15)));
            4:    do_write(10'h200, {1'b0, d[6:0]});
            5:    do_read($urandom_range(1) ? 10'h200 : 10'h201);
            6: begin
               a = 10'($urandom_range(16, 1023));
               if (a == 10'h200) a = 10'h3FF;
               if ($urandom_range(1) != 0) do_read(a);
               else                        do_write(a, d);
            end
            default: do_write(10'h200, {1'b1, d[6:2], m_ctrl});
         endcase
      end
      drain();
      chk("final_mod_enable", mod_enable, m_ctrl[0]);
      chk("final_mapping", mapping, m_ctrl[1]);
      chk("final_err", err_sticky, m_err);
      chk("final_rdata_empty", rdata_empty, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
